// File: rtl/lsu_ram_ctrl_if.sv
// Request/response channel between the MEM stage and the load/store controller.
// The MEM stage is the master; the controller is the slave.
interface lsu_ram_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata
    );
endinterface

// File: rtl/lsu_ram_ctrl.sv
// lsu_ram_ctrl: MEM-stage load/store initiator for the data dual-port RAM.
// Byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW become word accesses; sub-word
// stores use read-modify-write. Misaligned, out-of-range and illegal-size
// requests complete with resp_err and never touch the RAM.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | ready for a request; first RAM access issued in accept cycle
// LD_RESP  | read word on ram_r_data; extend lane, register response
// RMW      | merge store bytes into the read word and write it back
// ST_RESP  | store completion pulse
// ERR_RESP | error completion pulse
module lsu_ram_ctrl #(
    parameter int DW      = 32,
    parameter int AW      = 12,
    parameter int MEM_NUM = 4096
) (
    input  logic           clk,
    input  logic           rst,
    lsu_ram_ctrl_if.slave  bus,
    output logic           ram_w_en,
    output logic [AW-1:0]  ram_w_addr,
    output logic [DW-1:0]  ram_w_data,
    output logic           ram_r_en,
    output logic [AW-1:0]  ram_r_addr,
    input  logic [DW-1:0]  ram_r_data
);
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {IDLE, LD_RESP, RMW, ST_RESP, ERR_RESP} state_t;

    state_t        state;
    logic [AW-1:0] cap_widx;
    logic [1:0]    cap_lane;
    logic [1:0]    cap_size;
    logic          cap_unsigned;
    logic [15:0]   cap_wdata;
    logic [AW-1:0] r_addr_q;
    logic [AW-1:0] w_addr_q;
    logic          resp_valid_q;
    logic          resp_err_q;
    logic [31:0]   resp_rdata_q;

    logic [AW-1:0] req_widx;
    logic [31:0]   req_word_full;
    logic          req_err;
    logic          accept;
    logic          idle_rd;
    logic          idle_wr;
    logic          rmw_wr;
    logic [DW-1:0] merged;
    logic [15:0]   lane_data;
    logic [31:0]   ld_data;

    // Classify the incoming request and decide which RAM access it starts.
    always_comb begin
        req_widx      = bus.req_addr[AW+1:2];
        req_word_full = {2'b00, bus.req_addr[31:2]};
        req_err       = (bus.req_size == SZ_ILL)
                     || (bus.req_size == SZ_HALF && bus.req_addr[0])
                     || (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00)
                     || (req_word_full >= 32'(MEM_NUM));
        accept        = (state == IDLE) && bus.req_valid;
        idle_rd       = accept && !req_err && (!bus.req_we || bus.req_size != SZ_WORD);
        idle_wr       = accept && !req_err && bus.req_we && bus.req_size == SZ_WORD;
        rmw_wr        = (state == RMW);
    end

    // Drive the RAM ports; enables are gated by reset so a held request cannot leak through.
    always_comb begin
        ram_r_en   = rst && idle_rd;
        ram_w_en   = rst && (idle_wr || rmw_wr);
        ram_r_addr = idle_rd ? req_widx : r_addr_q;
        ram_w_addr = idle_wr ? req_widx : (rmw_wr ? cap_widx : w_addr_q);
        ram_w_data = idle_wr ? bus.req_wdata : merged;
    end

    // Byte/half merge for read-modify-write and lane extraction for loads.
    always_comb begin
        merged = ram_r_data;
        if (cap_size == SZ_BYTE)
            merged[{cap_lane, 3'b000} +: 8] = cap_wdata[7:0];
        else
            merged[{cap_lane[1], 4'b0000} +: 16] = cap_wdata;
        lane_data = 16'(ram_r_data >> {cap_lane, 3'b000});
        case (cap_size)
            SZ_BYTE: ld_data = {{24{lane_data[7]  & ~cap_unsigned}}, lane_data[7:0]};
            SZ_HALF: ld_data = {{16{lane_data[15] & ~cap_unsigned}}, lane_data};
            default: ld_data = ram_r_data;
        endcase
    end

    // Sequencer: captures the request, walks the access states, registers the response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cap_widx     <= '0;
            cap_lane     <= '0;
            cap_size     <= '0;
            cap_unsigned <= 1'b0;
            cap_wdata    <= '0;
            r_addr_q     <= '0;
            w_addr_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            if (idle_rd)
                r_addr_q <= ram_r_addr;
            if (idle_wr || rmw_wr)
                w_addr_q <= ram_w_addr;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        cap_widx     <= req_widx;
                        cap_lane     <= bus.req_addr[1:0];
                        cap_size     <= bus.req_size;
                        cap_unsigned <= bus.req_unsigned;
                        cap_wdata    <= bus.req_wdata[15:0];
                        if (req_err) begin
                            state        <= ERR_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else if (!bus.req_we) begin
                            state <= LD_RESP;
                        end else if (bus.req_size == SZ_WORD) begin
                            state        <= ST_RESP;
                            resp_valid_q <= 1'b1;
                        end else begin
                            state <= RMW;
                        end
                    end
                end
                LD_RESP: begin
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= ld_data;
                    state        <= IDLE;
                end
                RMW: begin
                    resp_valid_q <= 1'b1;
                    state        <= ST_RESP;
                end
                ST_RESP, ERR_RESP: state <= IDLE;
                default:           state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
endmodule

// File: tb/tb_lsu_ram_ctrl.sv
// Bench for lsu_ram_ctrl: directed test-plan cases plus randomized traffic
// checked every cycle against a word-array model of memory and response timing.
module tb_lsu_ram_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ram_w_en, ram_r_en;
    logic [11:0] ram_w_addr, ram_r_addr;
    logic [31:0] ram_w_data;
    logic [31:0] ram_r_data = '0;
    logic [31:0] ram_mem [0:4095];
    logic [31:0] gold    [0:4095];
    logic        ram_filled = 1'b0;

    lsu_ram_ctrl_if bus();

    lsu_ram_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .ram_w_en   (ram_w_en),
        .ram_w_addr (ram_w_addr),
        .ram_w_data (ram_w_data),
        .ram_r_en   (ram_r_en),
        .ram_r_addr (ram_r_addr),
        .ram_r_data (ram_r_data)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic err; logic [31:0] data; } exp_t;
    exp_t q[$];

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          ready_at = 0;
    int          exp_r_cyc = -1, exp_r_addr = 0;
    int          exp_w_cyc = -1, exp_w_addr = 0;
    logic [31:0] exp_w_data = '0;
    logic        chk_en = 1'b1;
    logic        have_r = 1'b0, have_w = 1'b0;
    logic [11:0] last_r_addr = '0, last_w_addr = '0;
    logic        last_err = 1'b0;
    logic [31:0] last_rdata = '0;

    function automatic logic [31:0] init_word(int i);
        if (i == 1) return 32'h8899AABB;
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Data RAM: 1-cycle registered read.
    always @(posedge clk) begin
        if (!ram_filled) begin
            for (int i = 0; i < 4096; i++) ram_mem[i] <= init_word(i);
            ram_filled <= 1'b1;
        end
        if (ram_w_en) ram_mem[ram_w_addr] <= ram_w_data;
        if (ram_r_en) ram_r_data <= ram_mem[ram_r_addr];
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string n, input logic act, input logic exp);
        chk(n, {31'b0, act}, {31'b0, exp});
    endtask

    function automatic logic [31:0] model_ld(logic [31:0] w, int lane, int size, logic uns);
        logic [31:0] v;
        v = w >> (8 * lane);
        if (size == 0) begin
            v = v & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (size == 1) begin
            v = v & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_st(logic [31:0] w, int lane, int size, logic [31:0] d);
        logic [31:0] m;
        m = (size == 0) ? 32'hFF : 32'hFFFF;
        return (w & ~(m << (8 * lane))) | ((d & m) << (8 * lane));
    endfunction

    task automatic model_accept();
        logic [31:0] a;
        int          lane, sz, idx;
        logic        err;
        logic [31:0] nw;
        a    = bus.req_addr;
        lane = int'(a[1:0]);
        sz   = int'(bus.req_size);
        idx  = int'(a[13:2]);
        err  = (sz == 3) || (sz == 1 && a[0]) || (sz == 2 && lane != 0) || (a >= 32'h4000);
        if (err) begin
            q.push_back('{cyc + 1, 1'b1, 32'h0});
            ready_at = cyc + 2;
        end else if (!bus.req_we) begin
            q.push_back('{cyc + 2, 1'b0, model_ld(gold[idx], lane, sz, bus.req_unsigned)});
            exp_r_cyc = cyc; exp_r_addr = idx;
            ready_at = cyc + 2;
        end else if (sz == 2) begin
            gold[idx] = bus.req_wdata;
            exp_w_cyc = cyc; exp_w_addr = idx; exp_w_data = bus.req_wdata;
            q.push_back('{cyc + 1, 1'b0, 32'h0});
            ready_at = cyc + 2;
        end else begin
            nw = model_st(gold[idx], lane, sz, bus.req_wdata);
            exp_r_cyc = cyc; exp_r_addr = idx;
            exp_w_cyc = cyc + 1; exp_w_addr = idx; exp_w_data = nw;
            gold[idx] = nw;
            q.push_back('{cyc + 2, 1'b0, 32'h0});
            ready_at = cyc + 3;
        end
    endtask

    // Compare process: every falling edge, DUT outputs against the model.
    always @(negedge clk) begin
        cyc++;
        if (rst && chk_en) begin
            chk1("req_ready", bus.req_ready, cyc >= ready_at);
            if (q.size() > 0 && q[0].cyc == cyc) begin
                chk1("resp_valid", bus.resp_valid, 1'b1);
                chk1("resp_err", bus.resp_err, q[0].err);
                chk("resp_rdata", bus.resp_rdata, q[0].data);
                last_err   = bus.resp_err;
                last_rdata = bus.resp_rdata;
                void'(q.pop_front());
            end else begin
                chk1("resp_valid_idle", bus.resp_valid, 1'b0);
            end
            if (bus.req_ready && bus.req_valid) model_accept();
            chk1("ram_r_en", ram_r_en, exp_r_cyc == cyc);
            if (exp_r_cyc == cyc) chk("ram_r_addr", 32'(ram_r_addr), 32'(exp_r_addr));
            chk1("ram_w_en", ram_w_en, exp_w_cyc == cyc);
            if (exp_w_cyc == cyc) begin
                chk("ram_w_addr", 32'(ram_w_addr), 32'(exp_w_addr));
                chk("ram_w_data", ram_w_data, exp_w_data);
            end
            if (!ram_r_en && have_r) chk("r_addr_hold", 32'(ram_r_addr), 32'(last_r_addr));
            if (!ram_w_en && have_w) chk("w_addr_hold", 32'(ram_w_addr), 32'(last_w_addr));
            if (ram_r_en) begin last_r_addr = ram_r_addr; have_r = 1'b1; end
            if (ram_w_en) begin last_w_addr = ram_w_addr; have_w = 1'b1; end
        end
    end

    task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input logic hold);
        int n;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
        bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wd;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (bus.req_ready) break;
            n++;
            if (n > 20) begin
                chk1("accept_timeout", 1'b0, 1'b1);
                break;
            end
        end
        @(posedge clk); #1;
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || cyc < ready_at) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk1("drain_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic rand_req(output logic we, output logic [1:0] sz, output logic uns,
                            output logic [31:0] addr, output logic [31:0] wd);
        we  = 1'($urandom_range(0, 1));
        sz  = 2'($urandom_range(0, 3));
        if (sz == 2'b11 && $urandom_range(0, 3) != 0) sz = 2'b10;
        uns = 1'($urandom_range(0, 1));
        wd  = $urandom;
        case ($urandom_range(0, 15))
            0:       addr = 32'h4000 + 32'($urandom_range(0, 255));
            1:       addr = $urandom | 32'h8000_0000;
            default: addr = 32'($urandom_range(0, 63));
        endcase
        if ($urandom_range(0, 2) != 0) begin
            if (sz == 2'b01) addr[0] = 1'b0;
            if (sz == 2'b10) addr[1:0] = 2'b00;
        end
    endtask

    task automatic run_random(input int n, input logic hold);
        logic we, uns;
        logic [1:0] sz;
        logic [31:0] a, d;
        for (int i = 0; i < n; i++) begin
            rand_req(we, sz, uns, a, d);
            send(we, sz, uns, a, d, hold);
            if (!hold) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        bus.req_valid = 1'b0;
        drain();
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < 4096; i++) gold[i] = init_word(i);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h4; bus.req_wdata = 32'h0;

        // Pin the model against hand-computed values.
        chk("pin_lb",  model_ld(gold[1], 1, 0, 1'b0), 32'hFFFFFFAA);
        chk("pin_lhu", model_ld(gold[1], 2, 1, 1'b1), 32'h00008899);
        chk("pin_sh",  model_st(gold[1], 2, 1, 32'h1234), 32'h1234AABB);
        chk("pin_sb",  model_st(32'h1234AABB, 0, 0, 32'h55), 32'h1234AA55);

        // Reset holds everything quiet even with a request pending.
        repeat (3) begin
            @(negedge clk);
            chk1("rst_r_en", ram_r_en, 1'b0);
            chk1("rst_w_en", ram_w_en, 1'b0);
            chk1("rst_resp_valid", bus.resp_valid, 1'b0);
            chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        end
        bus.req_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        // Directed loads from word 1.
        send(1'b0, 2'b00, 1'b0, 32'h5, 32'h0, 1'b0); repeat (3) @(negedge clk);
        chk("lb_0x5", last_rdata, 32'hFFFFFFAA);
        send(1'b0, 2'b00, 1'b1, 32'h5, 32'h0, 1'b0); repeat (3) @(negedge clk);
        chk("lbu_0x5", last_rdata, 32'h000000AA);
        send(1'b0, 2'b01, 1'b0, 32'h6, 32'h0, 1'b0); repeat (3) @(negedge clk);
        chk("lh_0x6", last_rdata, 32'hFFFF8899);
        send(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b0); repeat (3) @(negedge clk);
        chk("lw_0x4", last_rdata, 32'h8899AABB);

        // Word store then read back.
        send(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, 1'b0); repeat (3) @(negedge clk);
        chk("sw_ram2", ram_mem[2], 32'hDEADBEEF);
        send(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 1'b0); repeat (3) @(negedge clk);
        chk("lw_0x8", last_rdata, 32'hDEADBEEF);

        // Sub-word stores via read-modify-write.
        send(1'b1, 2'b01, 1'b0, 32'h6, 32'h1234, 1'b0); repeat (3) @(negedge clk);
        chk("sh_ram1", ram_mem[1], 32'h1234AABB);
        send(1'b1, 2'b00, 1'b0, 32'h4, 32'h55, 1'b0); repeat (3) @(negedge clk);
        chk("sb_ram1", ram_mem[1], 32'h1234AA55);

        // Error cases.
        send(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 1'b0); repeat (2) @(negedge clk);
        chk1("err_lw2", last_err, 1'b1);
        send(1'b0, 2'b01, 1'b0, 32'h3, 32'h0, 1'b0); repeat (2) @(negedge clk);
        chk1("err_lh3", last_err, 1'b1);
        send(1'b1, 2'b11, 1'b0, 32'h0, 32'h0, 1'b0); repeat (2) @(negedge clk);
        chk1("err_size3", last_err, 1'b1);
        send(1'b0, 2'b10, 1'b0, 32'h4000, 32'h0, 1'b0); repeat (2) @(negedge clk);
        chk1("err_range", last_err, 1'b1);
        chk("err_rdata", last_rdata, 32'h0);
        drain();

        // Back-to-back with req_valid held, then traffic with idle gaps.
        run_random(150, 1'b1);
        run_random(150, 1'b0);

        // Reset in the middle of a read-modify-write.
        chk_en = 1'b0;
        send(1'b1, 2'b00, 1'b0, 32'hC, 32'h77, 1'b0);
        #1 rst = 1'b0;
        #1;
        chk1("mid_rst_w_en", ram_w_en, 1'b0);
        chk1("mid_rst_r_en", ram_r_en, 1'b0);
        chk1("mid_rst_resp_valid", bus.resp_valid, 1'b0);
        chk1("mid_rst_resp_err", bus.resp_err, 1'b0);
        chk("mid_rst_resp_rdata", bus.resp_rdata, 32'h0);
        cnt = 0;
        repeat (3) begin @(negedge clk); if (ram_w_en || bus.resp_valid) cnt++; end
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) begin @(negedge clk); if (ram_w_en || bus.resp_valid) cnt++; end
        chk("mid_rst_activity", 32'(cnt), 32'h0);
        chk("mid_rst_ram3", ram_mem[3], gold[3]);
        q.delete();
        ready_at = 0; exp_r_cyc = -1; exp_w_cyc = -1;
        have_r = 1'b0; have_w = 1'b0;
        @(posedge clk); #1 chk_en = 1'b1;

        send(1'b0, 2'b10, 1'b0, 32'hC, 32'h0, 1'b0); repeat (3) @(negedge clk);
        chk("post_rst_lw", last_rdata, gold[3]);
        run_random(100, 1'b0);

        for (int i = 0; i < 16; i++) chk("final_mem", ram_mem[i], gold[i]);
        chk("final_queue", 32'(q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/lsu_ram_ctrl.md
Name: lsu_ram_ctrl

Overview:
Load/store initiator that drives the write/read port pair of the core's data dual-port RAM (1-cycle registered read, write-first bypass on same-address collision) on behalf of the pipeline's memory stage. Converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-wide RAM accesses. Sub-word stores use read-modify-write; misaligned or out-of-range accesses return an error. Sits between the MEM stage and the data RAM.

Parameters:
DW, 32, RAM word width (fixed 32 for RV32; other values unsupported)
AW, 12, RAM word-address width
MEM_NUM, 4096, RAM depth in words (must equal 2**AW)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
req_valid  input  1  request strobe, sampled when req_ready=1
req_ready  output  1  controller idle, request accepted this cycle if req_valid=1
req_we  input  1  1=store, 0=load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  loads: 1=zero-extend, 0=sign-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  one-cycle completion pulse
resp_err  output  1  valid with resp_valid: misaligned/out-of-range/illegal size
resp_rdata  output  32  load result, valid with resp_valid; 0 for stores/errors
ram_w_en  output  1  RAM write enable
ram_w_addr  output  AW  RAM write word address
ram_w_data  output  32  RAM write data
ram_r_en  output  1  RAM read enable
ram_r_addr  output  AW  RAM read word address
ram_r_data  input  32  RAM read data, valid one cycle after ram_r_en

Behaviour:
- Reset (rst=0, async): state IDLE; resp_valid=0, resp_err=0, resp_rdata=0; all ram_* enables forced 0 regardless of req_valid; captured request registers cleared. Reset mid-transaction abandons it: no response, no partial write after release.
- Little-endian. Word index = req_addr[AW+1:2]; byte lane = req_addr[1:0].
- Error if: size=11; half with addr[0]=1; word with addr[1:0]!=0; addr[31:AW+2]!=0. Errors issue no RAM enable.
- States: IDLE, LD_RESP, RMW, ST_RESP, ERR_RESP.
- IDLE: req_ready=1. On req_valid, capture request, then:
  - error -> ERR_RESP.
  - load -> ram_r_en=1 with ram_r_addr combinationally from req_addr this cycle -> LD_RESP.
  - word store -> ram_w_en=1, ram_w_data=req_wdata this cycle -> ST_RESP.
  - byte/half store -> ram_r_en=1 this cycle -> RMW.
- LD_RESP: select lane from ram_r_data, extend per size/unsigned; resp_valid=1 with registered resp_rdata in the following cycle -> IDLE. Load latency: response 2 cycles after accept.
- RMW: merge captured store bytes into ram_r_data, ram_w_en=1 to the same address -> ST_RESP.
- ST_RESP: resp_valid=1, resp_err=0, resp_rdata=0 -> IDLE.
- ERR_RESP: resp_valid=1, resp_err=1, resp_rdata=0 -> IDLE.
- req_ready=0 in every state except IDLE. Requests arriving then are ignored and must be held by the requester. No response backpressure.
- ram_r_en and ram_w_en are never both 1 in the same cycle.
- ram_w_addr and ram_r_addr hold their last value when not enabled.
- A store's write is at least 2 cycles before the next accepted read. No reliance on the RAM collision bypass is required.
- resp_valid is high for exactly one cycle per accepted request.

Test Plan:
- RAM[1]=0x8899AABB; LB addr 0x5 -> resp_rdata=0xFFFFFFAA; LBU addr 0x5 -> 0x000000AA; LH addr 0x6 -> 0xFFFF8899; LW addr 0x4 -> 0x8899AABB. Each response comes 2 cycles after accept.
- SW 0xDEADBEEF to 0x8 -> one ram_w_en pulse at word 2 in the accept cycle, resp_valid next cycle; LW 0x8 then returns 0xDEADBEEF.
- RAM[1]=0x8899AABB; SH 0x1234 to 0x6 -> read, then write 0x1234AABB. SB 0x55 to 0x4 -> RAM[1]=0x1234AA55.
- LW 0x2, LH 0x3, size=11, addr 0x00004000 (AW=12) -> resp_err=1, resp_rdata=0, no ram enables asserted.
- Hold req_valid=1 with back-to-back requests -> req_ready pulses only in IDLE, exactly one resp_valid per accept, order preserved.
- Assert rst low in RMW state -> outputs zero immediately, no ram_w_en afterwards, RAM word unchanged; first request after release completes normally.
